// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: opcodes, ALUOp encodings, control/ID-EX bundle
// layouts and ID/EX bit positions reused by the EX stage.
package cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam int IDEX_W          = 148;
    localparam int IDEX_REG_WRITE  = 147;
    localparam int IDEX_MEM_TO_REG = 146;
    localparam int IDEX_MEM_WRITE  = 145;
    localparam int IDEX_MEM_READ   = 144;
    localparam int IDEX_BRANCH     = 143;
    localparam int IDEX_JUMP       = 142;
    localparam int IDEX_REG_DST    = 141;
    localparam int IDEX_ALU_SRC    = 140;
    localparam int IDEX_ALU_OP_LSB = 138;
    localparam int IDEX_PC4_LSB    = 106;
    localparam int IDEX_RS_DATA_LSB = 74;
    localparam int IDEX_RT_DATA_LSB = 42;
    localparam int IDEX_IMM_LSB    = 10;
    localparam int IDEX_RT_LSB     = 5;
    localparam int IDEX_RD_LSB     = 0;

    // Field order matches the ID/EX bit layout, MSB first.
    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic       mem_read;
        logic       branch;
        logic       jump;
        logic       reg_dst;
        logic       alu_src;
        logic [1:0] alu_op;
    } ctrl_t;

    typedef struct packed {
        ctrl_t       ctrl;
        logic [31:0] pc4;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } idex_t;

    function automatic logic [31:0] sign_ext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/regfile.sv
// 32x32 register file: two combinational read ports, one write port, r0 fixed
// at zero. Optional write-to-read forwarding under ID_WB_BYPASS_EN.
module regfile
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic [31:0] rs_data,
    output logic [31:0] rt_data,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data
);

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];
    logic        wr_en;

    assign wr_en = wb_we && (wb_addr != 5'd0);

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign regs_d[gi] = '0;
            end else begin : g_data
                assign regs_d[gi] = (wr_en && (wb_addr == 5'(gi))) ? wb_data : regs_q[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rs_data = regs_q[rs_addr];
        rt_data = regs_q[rt_addr];
`ifdef ID_WB_BYPASS_EN
        // Behaves like a first-half-cycle write, second-half-cycle read.
        if (wr_en && (wb_addr == rs_addr)) rs_data = wb_data;
        if (wr_en && (wb_addr == rt_addr)) rt_data = wb_data;
`endif
    end

endmodule

// File: rtl/id_stage.sv
// Instruction decode stage: control decode, operand read, immediate extension,
// registered ID/EX bundle. Optional write-back bypass via ID_WB_BYPASS_EN.
module id_stage
    import cpu_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [63:0]   ifid,
    input  logic [31:0]   wb_data,
    input  logic [4:0]    wb_addr,
    input  logic          wb_we,
    output logic [147:0]  idex
);

    logic [31:0] pc4;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    ctrl_t       ctrl;
    logic [31:0] imm_ext;
    idex_t       idex_d;
    idex_t       idex_q;

    assign pc4    = ifid[63:32];
    assign instr  = ifid[31:0];
    assign opcode = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];

    regfile u_regfile (
        .clk     (clk),
        .rst     (rst),
        .rs_addr (rs),
        .rt_addr (rt),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .wb_we   (wb_we),
        .wb_addr (wb_addr),
        .wb_data (wb_data)
    );

    // Unlisted opcodes keep every control bit low and pass through as a bubble.
    always_comb begin
        ctrl = '0;
        case (opcode)
            OP_RTYPE: ctrl = '{reg_write: 1'b1, reg_dst: 1'b1, alu_op: ALUOP_FUNCT, default: 1'b0};
            OP_LW:    ctrl = '{reg_write: 1'b1, mem_to_reg: 1'b1, mem_read: 1'b1, alu_src: 1'b1,
                               alu_op: ALUOP_ADD, default: 1'b0};
            OP_SW:    ctrl = '{mem_write: 1'b1, alu_src: 1'b1, alu_op: ALUOP_ADD, default: 1'b0};
            OP_BEQ:   ctrl = '{branch: 1'b1, alu_op: ALUOP_SUB, default: 1'b0};
            OP_ADDI,
            OP_ADDIU: ctrl = '{reg_write: 1'b1, alu_src: 1'b1, alu_op: ALUOP_ADD, default: 1'b0};
            OP_J:     ctrl = '{jump: 1'b1, alu_op: ALUOP_ADD, default: 1'b0};
            default:  ctrl = '0;
        endcase
    end

    always_comb begin
        imm_ext = sign_ext16(instr[15:0]);
        if (opcode == OP_J) imm_ext = {6'b0, instr[25:0]};
    end

    always_comb begin
        idex_d         = '0;
        idex_d.ctrl    = ctrl;
        idex_d.pc4     = pc4;
        idex_d.rs_data = rs_data;
        idex_d.rt_data = rt_data;
        idex_d.imm     = imm_ext;
        idex_d.rt      = rt;
        idex_d.rd      = rd;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign idex = idex_q;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed steps then randomized traffic
// against an array-based register-file model and a table-driven decoder.
module tb_id_stage;

    logic         clk;
    logic         rst;
    logic [63:0]  ifid;
    logic [31:0]  wb_data;
    logic [4:0]   wb_addr;
    logic         wb_we;
    logic [147:0] idex;

    int checks;
    int errors;

    logic [31:0] model_regs [32];
    logic [147:0] exp_idex;

    id_stage dut (
        .clk     (clk),
        .rst     (rst),
        .ifid    (ifid),
        .wb_data (wb_data),
        .wb_addr (wb_addr),
        .wb_we   (wb_we),
        .idex    (idex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control word per opcode in order RegWrite..ALUOp, taken straight from the decode table.
    function automatic logic [9:0] ref_ctrl(input logic [5:0] op);
        logic [9:0] c;
        c = 10'b0;
        if (op == 6'h00) c = 10'b1000001010;
        if (op == 6'h23) c = 10'b1101000100;
        if (op == 6'h2B) c = 10'b0010000100;
        if (op == 6'h04) c = 10'b0000100001;
        if (op == 6'h08 || op == 6'h09) c = 10'b1000000100;
        if (op == 6'h02) c = 10'b0000010000;
        return c;
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] a, input logic we,
                                             input logic [4:0] wa, input logic [31:0] wd,
                                             input logic [31:0] stored);
        logic [31:0] v;
        v = (a == 5'd0) ? 32'd0 : stored;
`ifdef ID_WB_BYPASS_EN
        if (we && wa != 5'd0 && wa == a) v = wd;
`endif
        return v;
    endfunction

    function automatic logic [147:0] ref_idex(input logic [63:0] f, input logic [31:0] rsv,
                                              input logic [31:0] rtv);
        logic [31:0] ins;
        logic [31:0] imm;
        int unsigned imm16;
        ins   = f[31:0];
        imm16 = ins[15:0];
        if (ins[31:26] == 6'h02) imm = ins & 32'h03FF_FFFF;
        else if (imm16 >= 32768) imm = imm16 + 32'hFFFF_0000;
        else imm = imm16;
        return {ref_ctrl(ins[31:26]), f[63:32], rsv, rtv, imm, ins[20:16], ins[15:11]};
    endfunction

    // One clock: predict, advance the model, then check 1 ns after the edge.
    task automatic cycle(input logic r, input logic [63:0] f, input logic we,
                         input logic [4:0] wa, input logic [31:0] wd, input string tag);
        logic [4:0] rs_a;
        logic [4:0] rt_a;
        rst = r; ifid = f; wb_we = we; wb_addr = wa; wb_data = wd;
        rs_a = f[25:21];
        rt_a = f[20:16];
        if (r) exp_idex = '0;
        else exp_idex = ref_idex(f, ref_read(rs_a, we, wa, wd, model_regs[rs_a]),
                                    ref_read(rt_a, we, wa, wd, model_regs[rt_a]));
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
        end else if (we && wa != 5'd0) begin
            model_regs[wa] = wd;
        end
        #1;
        checks++;
        assert (idex === exp_idex) else begin
            errors++;
            $error("FAIL %s: idex=%h expected=%h", tag, idex, exp_idex);
        end
    endtask

    task automatic check_field(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got=%h expected=%h", tag, got, want);
        end
    endtask

    initial begin
        logic [5:0]  ops [8];
        logic [31:0] ins;
        logic [31:0] want_rt;
        checks = 0;
        errors = 0;
        for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
        ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h09, 6'h02, 6'h3F};
        rst = 1'b1; ifid = '1; wb_we = 1'b0; wb_addr = '0; wb_data = '0;

        // Reset with all-ones input and a competing write-back
        cycle(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 5'd5, 32'h1234_5678, "reset");
        cycle(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 5'd0, 32'h0, "reset_hold");
        check_field("reset_zero", 32'(idex == '0), 32'd1);
        $display("step reset: idex=%h", idex);

        // add $3,$1,$2 while writing r2=1
        cycle(1'b0, {32'h4, 32'h0022_1820}, 1'b1, 5'd2, 32'd1, "add_first");
`ifdef ID_WB_BYPASS_EN
        want_rt = 32'd1;
`else
        want_rt = 32'd0;
`endif
        check_field("add_rt_first", idex[73:42], want_rt);
        check_field("add_ctrl", 32'(idex[147:138]), 32'b1000001010);
        check_field("add_rd", 32'(idex[4:0]), 32'd3);
        check_field("add_rt", 32'(idex[9:5]), 32'd2);
        cycle(1'b0, {32'h4, 32'h0022_1820}, 1'b0, 5'd0, 32'd0, "add_second");
        check_field("add_rt_second", idex[73:42], 32'd1);
        $display("step add: rt_data=%h", idex[73:42]);

        // lw
        cycle(1'b0, {32'h8, 32'h8C22_FFFC}, 1'b0, 5'd0, 32'd0, "lw");
        check_field("lw_imm", idex[41:10], 32'hFFFF_FFFC);
        check_field("lw_ctrl", 32'(idex[147:138]), 32'b1101000100);
        check_field("lw_pc4", idex[137:106], 32'h8);
        $display("step lw: imm=%h", idex[41:10]);

        // j
        cycle(1'b0, {32'hC, 32'h0800_0010}, 1'b0, 5'd0, 32'd0, "j");
        check_field("j_imm", idex[41:10], 32'h0000_0010);
        check_field("j_ctrl", 32'(idex[147:138]), 32'b0000010000);
        $display("step j: imm=%h", idex[41:10]);

        // r0 write ignored, then read rs=0 with unknown opcode
        cycle(1'b0, {32'h10, 32'h0000_0000}, 1'b1, 5'd0, 32'h0000_DEAD, "r0_write");
        cycle(1'b0, {32'h14, 32'hFC00_0000}, 1'b0, 5'd0, 32'd0, "r0_read");
        check_field("r0_rs_data", idex[105:74], 32'd0);
        check_field("bubble_ctrl", 32'(idex[147:138]), 32'd0);
        $display("step r0/bubble: rs_data=%h", idex[105:74]);

        // Randomized traffic; small register range keeps read/write collisions frequent
        for (int n = 0; n < 300; n++) begin
            logic r;
            logic [63:0] f;
            ins = $urandom;
            ins[31:26] = ops[$urandom_range(0, 7)];
            if ($urandom_range(0, 3) != 0) begin
                ins[25:21] = 5'($urandom_range(0, 7));
                ins[20:16] = 5'($urandom_range(0, 7));
            end
            f = {32'($urandom), ins};
            r = ($urandom_range(0, 49) == 0);
            cycle(r, f, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 32'($urandom), "random");
            $display("rand %0d: rst=%0b ifid=%h idex=%h", n, r, f, idex);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
